// File: rtl/four_port_write_arbiter.sv
// Four-port write arbiter: buffers one pending write per core and issues
// them one at a time over a single registered write port into the shared
// byte array.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (port 0 highest);
// the default build arbitrates round-robin.
module four_port_write_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              req2,
    input  logic              req3,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] data3,
    output logic              ack0,
    output logic              ack1,
    output logic              ack2,
    output logic              ack3,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [1:0]        wr_port,
    output logic              busy
);

    logic [3:0]        req_vec;
    logic [ADDR_W-1:0] addr_arr [4];
    logic [DATA_W-1:0] data_arr [4];

    logic [3:0]        pend_q;
    logic [3:0]        pend_d;
    logic [ADDR_W-1:0] pend_addr_q [4];
    logic [DATA_W-1:0] pend_data_q [4];
    logic [3:0]        ack_q;

    logic [3:0]        cap;
    logic              gnt_valid;
    logic [1:0]        gnt_idx;
    logic [1:0]        cand;
    logic [3:0]        gnt_oh;

`ifndef ARB_FIXED_PRIO_EN
    logic [1:0]        rr_ptr_q;
`endif

    assign req_vec     = {req3, req2, req1, req0};
    assign addr_arr[0] = addr0;
    assign addr_arr[1] = addr1;
    assign addr_arr[2] = addr2;
    assign addr_arr[3] = addr3;
    assign data_arr[0] = data0;
    assign data_arr[1] = data1;
    assign data_arr[2] = data2;
    assign data_arr[3] = data3;

    assign ack0 = ack_q[0];
    assign ack1 = ack_q[1];
    assign ack2 = ack_q[2];
    assign ack3 = ack_q[3];

    // Pick the winning pending port; later loop iterations have higher priority.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        cand      = 2'd0;
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 3; i >= 0; i--) begin
            cand = 2'(i);
            if (pend_q[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
`else
        // k = 4 wraps to rr_ptr itself, the lowest-priority candidate.
        for (int k = 4; k >= 1; k--) begin
            cand = rr_ptr_q + 2'(k);
            if (pend_q[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
`endif
    end

    // Capture mask and next pending set; a port still showing ack is blanked.
    always_comb begin
        cap    = req_vec & ~pend_q & ~ack_q;
        gnt_oh = gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000;
        pend_d = (pend_q & ~gnt_oh) | cap;
    end

    // Pending flags, handshake and registered write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q  <= 4'b0000;
            ack_q   <= 4'b0000;
            busy    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_port <= 2'd0;
        end else begin
            pend_q <= pend_d;
            ack_q  <= gnt_oh;
            busy   <= |pend_d;
            wr_en  <= gnt_valid;
            // Write bus holds its last value when idle.
            if (gnt_valid) begin
                wr_addr <= pend_addr_q[gnt_idx];
                wr_data <= pend_data_q[gnt_idx];
                wr_port <= gnt_idx;
            end
        end
    end

    // Per-port address/data buffers, loaded on capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                pend_addr_q[i] <= '0;
                pend_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cap[i]) begin
                    pend_addr_q[i] <= addr_arr[i];
                    pend_data_q[i] <= data_arr[i];
                end
            end
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    // Round-robin pointer remembers the last granted port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= 2'd3;
        end else if (gnt_valid) begin
            rr_ptr_q <= gnt_idx;
        end
    end
`endif

endmodule

// File: tb/tb_four_port_write_arbiter.sv
// Self-checking bench for four_port_write_arbiter: directed vector table,
// hand-written corner sequences and random traffic against a reference model.
module tb_four_port_write_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    req = 4'b0000;
    logic [AW-1:0] addr [4];
    logic [DW-1:0] data [4];
    logic          ack0, ack1, ack2, ack3;
    logic [3:0]    ack;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    wr_port;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    assign ack = {ack3, ack2, ack1, ack0};

    four_port_write_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]),
        .addr0(addr[0]), .addr1(addr[1]), .addr2(addr[2]), .addr3(addr[3]),
        .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
        .ack0(ack0), .ack1(ack1), .ack2(ack2), .ack3(ack3),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_port(wr_port),
        .busy(busy)
    );

    // Reference model: pending set plus the identity of the last winner.
    bit            m_pend [4];
    logic [AW-1:0] m_paddr [4];
    logic [DW-1:0] m_pdata [4];
    int            m_last;
    logic [3:0]    m_ack;
    bit            m_wr_en;
    logic [AW-1:0] m_wr_addr;
    logic [DW-1:0] m_wr_data;
    logic [1:0]    m_wr_port;
    bit            m_busy;

    logic [DW-1:0] mem_dut [256];
    int            wseq [$];

    typedef struct {
        logic [3:0] req;
        logic       exp_en;
        logic [1:0] exp_port;
        logic [3:0] exp_ack;
        logic       exp_busy;
    } vec_t;
    vec_t tbl [6];

    int pb;
    int first_ack;
    int repeats;
    int cnt0;
    int cntb;

    function automatic void model_reset();
        for (int n = 0; n < 4; n++) begin
            m_pend[n]  = 1'b0;
            m_paddr[n] = '0;
            m_pdata[n] = '0;
        end
        m_last    = 3;
        m_ack     = 4'b0000;
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
        m_wr_port = 2'd0;
        m_busy    = 1'b0;
    endfunction

    function automatic void model_step();
        bit cap [4];
        int win;
        win = -1;
        for (int n = 0; n < 4; n++) cap[n] = req[n] && !m_pend[n] && !m_ack[n];
`ifdef ARB_FIXED_PRIO_EN
        for (int p = 0; p < 4; p++) if (m_pend[p] && win < 0) win = p;
`else
        for (int k = 1; k <= 4; k++) begin
            automatic int p = (m_last + k) % 4;
            if (m_pend[p] && win < 0) win = p;
        end
`endif
        m_ack = 4'b0000;
        if (win >= 0) begin
            m_wr_en     = 1'b1;
            m_wr_addr   = m_paddr[win];
            m_wr_data   = m_pdata[win];
            m_wr_port   = 2'(win);
            m_ack[win]  = 1'b1;
            m_pend[win] = 1'b0;
            m_last      = win;
        end else begin
            m_wr_en = 1'b0;
        end
        for (int n = 0; n < 4; n++) begin
            if (cap[n]) begin
                m_pend[n]  = 1'b1;
                m_paddr[n] = addr[n];
                m_pdata[n] = data[n];
            end
        end
        m_busy = m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3];
    endfunction

    function automatic logic [31:0] dut_vec();
        return {8'b0, ack, wr_en, wr_addr, wr_data, wr_port, busy};
    endfunction

    function automatic logic [31:0] model_vec();
        return {8'b0, m_ack, m_wr_en, m_wr_addr, m_wr_data, m_wr_port, m_busy};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One clock: advance the model, wait for the edge, compare all outputs.
    task automatic tick(input string name);
        model_step();
        @(posedge clk);
        #1;
        check(name, dut_vec(), model_vec());
        if (wr_en === 1'b1) begin
            mem_dut[wr_addr] = wr_data;
            wseq.push_back(int'(wr_port));
        end
    endtask

    task automatic drop_acked();
        for (int n = 0; n < 4; n++) if (ack[n] === 1'b1) req[n] = 1'b0;
    endtask

    task automatic apply_reset();
        req = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            addr[n] = '0;
            data[n] = '0;
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("reset_state", dut_vec(), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        wseq.delete();
    endtask

    initial begin
        tbl[0] = '{4'b1111, 1'b0, 2'd0, 4'b0000, 1'b1};
        tbl[1] = '{4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1};
        tbl[2] = '{4'b1110, 1'b1, 2'd1, 4'b0010, 1'b1};
        tbl[3] = '{4'b1100, 1'b1, 2'd2, 4'b0100, 1'b1};
        tbl[4] = '{4'b1000, 1'b1, 2'd3, 4'b1000, 1'b0};
        tbl[5] = '{4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0};

        // Single uncontended write.
        apply_reset();
        req[1] = 1'b1; addr[1] = 8'h10; data[1] = 8'hA5;
        tick("single_e0");
        check("single_busy_after_capture", {wr_en, busy}, 2'b01);
        tick("single_e1");
        check("single_write", {wr_en, wr_addr, wr_data, wr_port, ack},
              {1'b1, 8'h10, 8'hA5, 2'd1, 4'b0010});
        drop_acked();
        tick("single_e2");
        check("single_ack_done", {ack, busy, wr_en}, 6'b0);
        repeat (3) begin
            tick("single_idle");
            check("single_no_wren", wr_en, 1'b0);
        end

        // All four ports at once, table-driven.
        apply_reset();
        for (int n = 0; n < 4; n++) begin
            addr[n] = 8'(n);
            data[n] = 8'(8'h40 + n);
        end
        for (int i = 0; i < 6; i++) begin
            req = tbl[i].req;
            tick("table_model");
            check("table_en", wr_en, tbl[i].exp_en);
            check("table_port", wr_port, tbl[i].exp_port);
            check("table_ack", ack, tbl[i].exp_ack);
            check("table_busy", busy, tbl[i].exp_busy);
            if (tbl[i].exp_en)
                check("table_payload", {wr_addr, wr_data},
                      {8'(tbl[i].exp_port), 8'(8'h40 + tbl[i].exp_port)});
        end

        // Same address from ports 1 and 3.
        apply_reset();
        mem_dut[8'h80] = 8'h00;
        req = 4'b1010;
        addr[1] = 8'h80; data[1] = 8'h11;
        addr[3] = 8'h80; data[3] = 8'h33;
        repeat (6) begin
            tick("collision");
            drop_acked();
        end
        check("collision_count", wseq.size(), 2);
        check("collision_first", (wseq.size() > 0) ? wseq[0] : 99, 1);
        check("collision_second", (wseq.size() > 1) ? wseq[1] : 99, 3);
        check("collision_final", mem_dut[8'h80], 8'h33);

        // Port 2 holds its request one cycle past ack.
        apply_reset();
        req[2] = 1'b1; addr[2] = 8'h22; data[2] = 8'h5A;
        first_ack = -1;
        tick("held_e0");
        tick("held_e1");
        check("held_ack_first", ack, 4'b0100);
        tick("held_e2");
        check("held_blanked", {ack, busy}, 5'b0);
        tick("held_e3");
        check("held_recapture", busy, 1'b1);
        req[2] = 1'b0;
        tick("held_e4");
        check("held_ack_second", {wr_en, wr_addr, wr_data, wr_port, ack},
              {1'b1, 8'h22, 8'h5A, 2'd2, 4'b0100});
        repeat (2) begin
            tick("held_idle");
            check("held_no_third", wr_en, 1'b0);
        end

        // Reset in mid-operation with ports 0, 2, 3 pending.
        apply_reset();
        req = 4'b1101;
        addr[0] = 8'h01; addr[2] = 8'h02; addr[3] = 8'h03;
        data[0] = 8'hC0; data[2] = 8'hC2; data[3] = 8'hC3;
        tick("midrst_e0");
        tick("midrst_e1");
        check("midrst_active", {wr_en, busy}, 2'b11);
        #3;
        reset = 1'b0;
        req = 4'b0000;
        model_reset();
        #1;
        check("midrst_outputs_cleared", dut_vec(), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) begin
            tick("midrst_idle");
            check("midrst_no_wren", wr_en, 1'b0);
        end

        // Two ports re-requesting right after every ack.
`ifdef ARB_FIXED_PRIO_EN
        pb = 1;
`else
        pb = 2;
`endif
        apply_reset();
        req[0] = 1'b1; req[pb] = 1'b1;
        addr[0] = 8'hA0; data[0] = 8'h0A;
        addr[pb] = 8'hB0; data[pb] = 8'h0B;
        for (int c = 0; c < 30; c++) begin
            tick("fair");
            req[0]  = (ack[0] === 1'b1) ? 1'b0 : 1'b1;
            req[pb] = (ack[pb] === 1'b1) ? 1'b0 : 1'b1;
        end
        cnt0 = 0; cntb = 0; repeats = 0;
        foreach (wseq[i]) begin
            if (wseq[i] == 0) cnt0++;
            if (wseq[i] == pb) cntb++;
            if (i > 0 && wseq[i] == wseq[i-1]) repeats++;
        end
        check("fair_port0_served", (cnt0 >= 5) ? 1 : 0, 1);
        check("fair_other_served", (cntb >= 5) ? 1 : 0, 1);
`ifndef ARB_FIXED_PRIO_EN
        check("fair_alternation", repeats, 0);
`endif

        // Random protocol-compliant traffic.
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            tick("random");
            for (int n = 0; n < 4; n++) begin
                if (ack[n] === 1'b1) begin
                    req[n] = 1'b0;
                end else if (!req[n] && $urandom_range(2) == 0) begin
                    req[n]  = 1'b1;
                    addr[n] = 8'($urandom);
                    data[n] = 8'($urandom);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/four_port_write_arbiter.md
Name: four_port_write_arbiter

Overview:
- Write-side companion to the four-port shared byte array, which has four combinational read ports and no write path.
- Accepts write requests from four cores over a per-port req/ack handshake and buffers one pending write per port.
- Arbitrates round-robin and drives a single registered write port (wr_en/wr_addr/wr_data) into the shared array.
- Sits between the four core bus interfaces and the shared array.

Parameters:
- ADDR_W, 8, address width; the array has 2^ADDR_W entries.
- DATA_W, 8, data width of each entry.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0..req3  in  1 each  write request from core N; held high until ackN is seen.
- addr0..addr3  in  ADDR_W each  write address for core N; stable while reqN is high.
- data0..data3  in  DATA_W each  write data for core N; stable while reqN is high.
- ack0..ack3  out  1 each  one-cycle pulse: core N's write was issued this cycle.
- wr_en  out  1  write strobe to the array, one-cycle pulse per write.
- wr_addr  out  ADDR_W  array write address.
- wr_data  out  DATA_W  array write data.
- wr_port  out  2  index of the port whose write is on wr_*.
- busy  out  1  high while any port has a pending write.

Behaviour:
- Reset (reset=0, takes effect immediately) clears all outputs and state:
  - ack0..ack3, wr_en, busy = 0; wr_addr, wr_data, wr_port = 0.
  - pend[3:0] = 0; rr_ptr = 3, so port 0 has first priority.
- Capture, per port N, at each edge: if reqN & ~pendN & ~ackN, then pendN<=1 and pend_addrN/pend_dataN<=addrN/dataN.
  - reqN sampled high while ackN=1 is ignored.
- Requester rule: drop reqN by the edge after ackN was observed. If reqN is still high after ackN falls, it is a new request.
- Grant (combinational from pend, registered outputs):
  - Search order rr_ptr+1, rr_ptr+2, rr_ptr+3, rr_ptr+4 (mod 4); the first pending port G wins.
  - At the edge: wr_en<=1, wr_addr<=pend_addrG, wr_data<=pend_dataG, wr_port<=G, ackG<=1, pendG<=0, rr_ptr<=G.
  - With no pending port: wr_en<=0 and all ack<=0. wr_addr/wr_data/wr_port hold their last values.
- Throughput and latency:
  - At most one write per cycle; back-to-back writes allowed.
  - Uncontended latency: req sampled at edge t, pend set at t, wr_en/ack high after edge t+1, a 2-cycle req-to-ack.
  - A single port sustains at most one write every 3 cycles (capture, grant, ack blanking).
- Capture and grant of different ports in the same edge are independent. A port cannot be captured and granted in the same edge.
- Same address from several ports: each write is issued separately in grant order; the last one issued wins in the array. No merging.
- busy = |pend, registered alongside pend.
- Reset mid-operation: pending writes are discarded without ack. Requesters re-issue after reset rises. No wr_en pulse until a new capture.
- Address and data pass through without arithmetic. Widths are exact; no truncation.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority, port 0 highest down to port 3. rr_ptr is not implemented; G is the lowest-index pending port.
- Undefined: round-robin as specified above.
- Ports, latency and handshake are identical in both builds.

Test Plan:
- Single write: after reset, req1=1, addr1=0x10, data1=0xA5 sampled at edge 0 -> after edge 1: wr_en=1, wr_addr=0x10, wr_data=0xA5, wr_port=1, ack1=1 for exactly 1 cycle; busy high one cycle; no further wr_en.
- All four requests at once: addrN=0x0N, dataN=0x40+N -> wr_en high 4 consecutive cycles with wr_port=0,1,2,3, ack pulses matching, busy falls after the last.
- Fairness: ports 0 and 2 re-request immediately after each ack -> grants alternate 0,2,0,2; neither port starves. With ARB_FIXED_PRIO_EN, ports 0 and 1 re-requesting -> port 1 granted only when pend0=0.
- Collision: ports 1 and 3 both write addr 0x80 with data 0x11/0x33 in the same cycle -> two writes, port 1 first then port 3; final data 0x33.
- Reset mid-op: ports 0, 2, 3 pending, pull reset low mid-cycle -> all outputs 0 immediately, busy=0. After release with no req: no wr_en for 10 cycles.
- Held request: port 2 keeps req2 high for one cycle past ack2 -> a second write of the same addr/data is captured and acked 3 cycles after the first ack.
